// File: rtl/colour_rom_arbiter.sv
//------------------------------------------------------------------------------
// colour_rom_arbiter
//
// Shares one registered colour ROM between two read ports. Port 0 is the
// display pipeline and port 1 the update/debug path. A grant is decided
// combinationally each cycle. The ROM is then driven with the granted address.
// A tag pipeline that matches the ROM latency steers rom_dout back to the
// port that issued the read.
//
// Parameters
//   ADDR_W    ROM address width
//   DATA_W    ROM word width
//   ROM_LAT   cycles from rom_en/rom_addr to valid rom_dout (1-4)
//   FIXED_PRI 1: port 0 has priority, and port 1 has a starvation guard
//             0: round-robin between the two ports
//   MAX_WAIT  consecutive denied cycles for port 1 before it is forced in (1-255)
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   p0_req/p0_addr           port 0 request and address
//   p0_gnt                   port 0 request accepted this cycle
//   p0_rvalid/p0_rdata       port 0 read response
//   p1_*                     port 1 equivalents
//   rom_en/rom_addr          ROM read enable and address
//   rom_dout                 ROM registered read data
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module colour_rom_arbiter #(
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 12,
   parameter int ROM_LAT   = 1,
   parameter int FIXED_PRI = 1,
   parameter int MAX_WAIT  = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic [ADDR_W-1:0] p0_addr,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic [ADDR_W-1:0] p1_addr,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout
);

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [7:0]         wait_cnt;
   port_e              last_gnt;
   logic [ROM_LAT-1:0] tag_vld;
   logic [ROM_LAT-1:0] tag_id;    // 1 = response belongs to port 1
   logic               pick_p1;

   // Grants are gated by rst_n so that every output is 0 during reset,
   // even while the requesters keep their req lines high.
   always_comb begin
      pick_p1 = 1'b0;
      p0_gnt  = 1'b0;
      p1_gnt  = 1'b0;
      if (rst_n) begin
         if (p0_req && p1_req) begin
            if (FIXED_PRI != 0)
               pick_p1 = (wait_cnt == MAX_WAIT_C);
            else
               pick_p1 = (last_gnt == PORT0);
            p0_gnt = ~pick_p1;
            p1_gnt = pick_p1;
         end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
         end
      end
   end

   assign rom_en   = p0_gnt | p1_gnt;
   assign rom_addr = p1_gnt ? p1_addr : (p0_gnt ? p0_addr : '0);

   // Counts consecutive denied cycles for port 1. A dropped request clears it,
   // so a forgotten request leaves no residual priority behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (p1_req && !p1_gnt) begin
         if (wait_cnt != MAX_WAIT_C)
            wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= '0;
      end
   end

   // Reset points at port 1, so port 0 wins the first round-robin contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt <= PORT1;
      else if (p0_gnt)
         last_gnt <= PORT0;
      else if (p1_gnt)
         last_gnt <= PORT1;
   end

   // The response tags shift at the same rate as the ROM's internal pipeline.
   // The cast drops the oldest entry, and it also handles ROM_LAT == 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld <= ROM_LAT'({tag_vld, rom_en});
         tag_id  <= ROM_LAT'({tag_id, p1_gnt});
      end
   end

   assign p0_rvalid = tag_vld[ROM_LAT-1] & ~tag_id[ROM_LAT-1];
   assign p1_rvalid = tag_vld[ROM_LAT-1] &  tag_id[ROM_LAT-1];
   assign p0_rdata  = rom_dout;
   assign p1_rdata  = rom_dout;

endmodule

// File: tb/tb_colour_rom_arbiter.sv
//------------------------------------------------------------------------------
// tb_colour_rom_arbiter
//
// Runs two arbiters side by side on a behavioural ROM:
//   k=0: FIXED_PRI=1, ROM_LAT=2, MAX_WAIT=7
//   k=1: FIXED_PRI=0, ROM_LAT=3
// A predictor derives each cycle's grant from the arbitration rules. It pushes
// {port, ROM word, due cycle} into a per-instance scoreboard queue. A separate
// monitor pops that queue whenever an rvalid appears.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_colour_rom_arbiter;
   localparam int AW   = 11;
   localparam int DW   = 12;
   localparam int MAXW = 7;
   localparam int LAT [2] = '{2, 3};
   localparam int FIX [2] = '{1, 0};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic          p0_req [2];
   logic          p1_req [2];
   logic [AW-1:0] p0_addr [2];
   logic [AW-1:0] p1_addr [2];
   logic          p0_gnt [2];
   logic          p1_gnt [2];
   logic          p0_rvalid [2];
   logic          p1_rvalid [2];
   logic [DW-1:0] p0_rdata [2];
   logic [DW-1:0] p1_rdata [2];
   logic          rom_en [2];
   logic [AW-1:0] rom_addr [2];
   logic [DW-1:0] rom_dout [2];

   logic [DW-1:0] rom_mem [2**AW];
   logic [DW-1:0] rom_pipe [2][4];

   typedef struct {
      int            port;
      logic [DW-1:0] data;
      longint        due;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   int     mwait [2];
   int     mlast [2];
   bit     count_en = 1'b0;
   int     p1_share [2];
   int     tot_share [2];

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      colour_rom_arbiter #(
         .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT[k]),
         .FIXED_PRI(FIX[k]), .MAX_WAIT(MAXW)
      ) dut (
         .clk(clk), .rst_n(rst_n),
         .p0_req(p0_req[k]), .p0_addr(p0_addr[k]), .p0_gnt(p0_gnt[k]),
         .p0_rvalid(p0_rvalid[k]), .p0_rdata(p0_rdata[k]),
         .p1_req(p1_req[k]), .p1_addr(p1_addr[k]), .p1_gnt(p1_gnt[k]),
         .p1_rvalid(p1_rvalid[k]), .p1_rdata(p1_rdata[k]),
         .rom_en(rom_en[k]), .rom_addr(rom_addr[k]), .rom_dout(rom_dout[k])
      );
      assign rom_dout[k] = rom_pipe[k][LAT[k]-1];
   end

   // Registered ROM with a latency of LAT[k] cycles.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         rom_pipe[k][0] <= rom_mem[rom_addr[k]];
         for (int j = 1; j < 4; j++) rom_pipe[k][j] <= rom_pipe[k][j-1];
      end
   end

   task automatic chk(input string name, input int k, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         default: return AW'($urandom_range(0, 2**AW - 1));
      endcase
   endfunction

   // Reset discards every read still in flight.
   initial forever begin
      @(negedge rst_n);
      q0.delete();
      q1.delete();
   end

   // Predictor: applies the arbitration rules, checks the grant, and enqueues the response.
   initial begin
      bit e0, e1;
      logic [AW-1:0] ea;
      exp_t e;
      for (int k = 0; k < 2; k++) begin mwait[k] = 0; mlast[k] = 1; end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            e0 = 1'b0; e1 = 1'b0;
            if (rst_n) begin
               if (p0_req[k] && p1_req[k]) begin
                  if (FIX[k] == 1) e1 = (mwait[k] == MAXW);
                  else             e1 = (mlast[k] == 0);
                  e0 = !e1;
               end else begin
                  e0 = p0_req[k];
                  e1 = p1_req[k];
               end
            end
            ea = e1 ? p1_addr[k] : (e0 ? p0_addr[k] : '0);
            chk("grant", k, 64'({p0_gnt[k], p1_gnt[k], rom_en[k], rom_addr[k]}),
                64'({e0, e1, e0 | e1, ea}));
            if (rst_n) begin
               if (e0 || e1) begin
                  e.port = e1 ? 1 : 0;
                  e.data = rom_mem[ea];
                  e.due  = cyc + LAT[k];
                  if (k == 0) q0.push_back(e); else q1.push_back(e);
                  if (count_en) begin
                     tot_share[k]++;
                     if (e1) p1_share[k]++;
                  end
               end
               if (p1_req[k] && !e1) mwait[k] = (mwait[k] < MAXW) ? mwait[k] + 1 : MAXW;
               else                  mwait[k] = 0;
               if (e0) mlast[k] = 0;
               if (e1) mlast[k] = 1;
            end else begin
               mwait[k] = 0;
               mlast[k] = 1;
            end
         end
      end
   end

   // Monitor: compares each response with the front of the scoreboard.
   initial begin
      bit v0, v1;
      int n;
      exp_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            v0 = p0_rvalid[k];
            v1 = p1_rvalid[k];
            n  = (k == 0) ? q0.size() : q1.size();
            if (v0 || v1) begin
               chk("rvalid_excl", k, 64'(v0 & v1), 64'd0);
               if (n == 0) begin
                  chk("unexpected_rvalid", k, 64'({v0, v1}), 64'd0);
               end else begin
                  e = (k == 0) ? q0.pop_front() : q1.pop_front();
                  chk("resp_port", k, 64'(v1), 64'(e.port));
                  chk("resp_cycle", k, 64'(cyc), 64'(e.due));
                  chk("resp_data", k, 64'(v1 ? p1_rdata[k] : p0_rdata[k]), 64'(e.data));
               end
            end else if (n > 0) begin
               e = (k == 0) ? q0[0] : q1[0];
               if (e.due <= cyc) begin
                  chk("missing_rvalid", k, 64'(cyc), 64'(e.due + 1));
                  if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
               end
            end
         end
      end
   end

   task automatic check_reset_outputs();
      for (int k = 0; k < 2; k++)
         chk("reset_outputs", k,
             64'({p0_gnt[k], p1_gnt[k], p0_rvalid[k], p1_rvalid[k], rom_en[k], rom_addr[k]}),
             64'd0);
   endtask

   task automatic step_random();
      bit g0 [2];
      bit g1 [2];
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin g0[k] = p0_gnt[k]; g1[k] = p1_gnt[k]; end
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (p0_req[k] && !g0[k]) begin
            if ($urandom_range(0, 9) == 0) p0_req[k] = 1'b0;
         end else begin
            p0_req[k]  = ($urandom_range(0, 3) != 0);
            p0_addr[k] = rand_addr();
         end
         if (p1_req[k] && !g1[k]) begin
            if ($urandom_range(0, 7) == 0) p1_req[k] = 1'b0;
         end else begin
            p1_req[k]  = ($urandom_range(0, 2) == 0);
            p1_addr[k] = rand_addr();
         end
      end
   endtask

   task automatic drive_all(input bit r0, input bit r1, input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1);
      for (int k = 0; k < 2; k++) begin
         p0_req[k] = r0; p1_req[k] = r1; p0_addr[k] = a0; p1_addr[k] = a1;
      end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) rom_mem[i] = DW'($urandom);
      for (int k = 0; k < 2; k++) begin p1_share[k] = 0; tot_share[k] = 0; end

      // Hold reset while both ports request. Every output must stay at 0.
      drive_all(1'b1, 1'b1, 11'h123, 11'h456);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      repeat (600) step_random();

      // Idle cycle: the starvation counter starts the contention run from 0.
      @(posedge clk); #1;
      drive_all(1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      drive_all(1'b1, 1'b1, 11'h010, 11'h7FF);
      count_en = 1'b1;
      repeat (64) @(posedge clk);
      #1;
      count_en = 1'b0;
      chk("fp_p1_share", 0, 64'(p1_share[0]), 64'd8);
      chk("fp_total", 0, 64'(tot_share[0]), 64'd64);
      chk("rr_p1_share", 1, 64'(p1_share[1]), 64'd32);
      chk("rr_total", 1, 64'(tot_share[1]), 64'd64);

      // A single p0 grant, then reset one cycle later with both ports requesting.
      drive_all(1'b1, 1'b0, 11'h2AA, '0);
      @(posedge clk); #1;
      drive_all(1'b1, 1'b1, 11'h3CC, 11'h155);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      drive_all(1'b0, 1'b0, '0, '0);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;

      repeat (300) step_random();

      @(posedge clk); #1;
      drive_all(1'b0, 1'b0, '0, '0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      #1;
      chk("drain", 0, 64'(q0.size()), 64'd0);
      chk("drain", 1, 64'(q1.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish by 200000 ns");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/colour_rom_arbiter.md
COLOUR_ROM_ARBITER -- requirements
Module: colour_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, ROM address width (2048 entries) SHALL be supported.
REQ-002 Parameter DATA_W, default 12, ROM word width (12-bit colour).
REQ-003 Parameter ROM_LAT, default 1, cycles from rom_en/rom_addr to valid rom_dout; legal range 1-4.
REQ-004 Parameter FIXED_PRI, default 1; 1 = port 0 strict priority with starvation guard, 0 = round-robin.
REQ-005 Parameter MAX_WAIT, default 7, consecutive denied cycles for port 1 before forced grant; legal range 1-255.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 p0_req  input  1  port 0 (display pipeline) read request.
REQ-009 p0_addr  input  ADDR_W  port 0 read address.
REQ-010 p0_gnt  output  1  port 0 request accepted this cycle.
REQ-011 p0_rvalid  output  1  p0_rdata valid this cycle.
REQ-012 p0_rdata  output  DATA_W  port 0 read data.
REQ-013 p1_req, p1_addr, p1_gnt, p1_rvalid, p1_rdata  same directions/widths  port 1 (update/debug) equivalents.
REQ-014 rom_en  output  1  ROM read enable.
REQ-015 rom_addr  output  ADDR_W  ROM address.
REQ-016 rom_dout  input  DATA_W  ROM registered read data.

Function
REQ-017 At most one grant per cycle; pN_gnt combinational from current req and arbiter state, asserted only when pN_req is high.
REQ-018 rom_en SHALL equal p0_gnt | p1_gnt; rom_addr SHALL equal the granted port's address, and 0 when no grant.
REQ-019 Single requester SHALL be granted in the same cycle regardless of mode.
REQ-020 FIXED_PRI=1, both requesting: p0 granted unless wait counter equals MAX_WAIT, in which case p1 granted.
REQ-021 Wait counter: increments (saturating at MAX_WAIT) each cycle p1_req high and p1_gnt low; clears to 0 on p1_gnt or when p1_req low.
REQ-022 FIXED_PRI=0, both requesting: grant the port not granted most recently; last-grant pointer updates only on a grant.
REQ-023 Requester holds req/addr until gnt; a request dropped before gnt SHALL be forgotten with no ROM access.
REQ-024 Response tag pipeline: ROM_LAT-stage shift register of {valid, port_id}; stage 0 loaded each cycle with {rom_en, granted id}.
REQ-025 pN_rvalid SHALL pulse exactly ROM_LAT cycles after the cycle pN_gnt was high, for one cycle per grant.
REQ-026 pN_rdata SHALL be rom_dout; value meaningful only while pN_rvalid high.
REQ-027 Back-to-back grants every cycle SHALL yield rvalid every cycle with no bubbles; responses in grant order.
REQ-028 p0_rvalid and p1_rvalid SHALL never be high in the same cycle.
REQ-029 Address wrap: addresses 0 and 2^ADDR_W-1 pass unmodified; no address arithmetic performed.

Reset
REQ-030 rst_n low SHALL asynchronously clear tag pipeline, wait counter and last-grant pointer (pointer = port 1, so port 0 wins first round-robin contention).
REQ-031 During reset all outputs SHALL be 0: gnt, rvalid, rom_en, rom_addr.
REQ-032 Reset mid-operation SHALL discard in-flight reads; no rvalid after reset release for grants issued before reset.
REQ-033 Deassertion of rst_n SHALL take effect at the next rising clk edge; first grant possible in that cycle.

Verification
REQ-034 p0_req only, addr 0..2047 sequential, ROM loaded from colour.data -> p0_rvalid every cycle from ROM_LAT after first grant, p0_rdata matches file line i, 0 mismatches.
REQ-035 FIXED_PRI=1, MAX_WAIT=7, both req continuously -> p0 granted 7 cycles, p1 on 8th, repeat; p1 gets 1 of every 8 grants.
REQ-036 FIXED_PRI=0, both req continuously, p0_addr=0x010, p1_addr=0x7FF -> grants alternate p0,p1,p0...; rvalids alternate with data ROM[0x010], ROM[0x7FF].
REQ-037 ROM_LAT=3, single p1 grant at cycle T -> p1_rvalid high only at T+3, p0_rvalid never high.
REQ-038 rst_n pulled low one cycle after a p0 grant with ROM_LAT=2 -> all outputs 0 immediately, no p0_rvalid after release.
REQ-039 p1_req raised then dropped before grant while p0 busy -> no p1_gnt, no p1_rvalid, wait counter back to 0.
